// File: rtl/secuencia_run_detector_if.sv
// Bus for the run-length sequence detector: sample/control inputs and
// detection outputs. The master drives the serial stream and controls;
// the detector is the slave.
interface secuencia_run_detector_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             w;
    logic [1:0]       mode;
    logic             overlap;
    logic             clr_cnt;
    logic             z;
    logic             det_pulse;
    logic [CNT_W-1:0] det_count;

    modport master (
        output en,
        output w,
        output mode,
        output overlap,
        output clr_cnt,
        input  z,
        input  det_pulse,
        input  det_count
    );

    modport slave (
        input  en,
        input  w,
        input  mode,
        input  overlap,
        input  clr_cnt,
        output z,
        output det_pulse,
        output det_count
    );
endinterface

// File: rtl/secuencia_run_detector.sv
// Parametrised Moore run detector. Tracks the length of the current run of
// equal, qualifying samples on w and flags when it reaches RUN_LEN. Mode
// selects which bit value qualifies (ones, zeros, either, none). Supports
// overlapping/non-overlapping detection and a saturating event counter.
module secuencia_run_detector #(
    parameter int RUN_LEN = 2,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    secuencia_run_detector_if.slave bus
);
    localparam int RW = $clog2(RUN_LEN + 1);
    localparam logic [RW-1:0]    RUN_MAX = RW'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        MODE_ONES  = 2'b00,
        MODE_ZEROS = 2'b01,
        MODE_ANY   = 2'b10,
        MODE_OFF   = 2'b11
    } mode_e;

    // Whether a sampled bit can extend a run under the given mode.
    function automatic logic qualifies(input mode_e m, input logic bit_v);
        logic q;
        case (m)
            MODE_ONES:  q = bit_v;
            MODE_ZEROS: q = ~bit_v;
            MODE_ANY:   q = 1'b1;
            MODE_OFF:   q = 1'b0;
            default:    q = 1'b0;
        endcase
        return q;
    endfunction

    logic [RW-1:0]    run_r;
    logic             bit_r;
    mode_e            mode_q_r;
    logic             z_r;
    logic             pulse_r;
    logic [CNT_W-1:0] cnt_r;

    mode_e            mode_s;
    logic             qual_s;
    logic [RW-1:0]    next_run_s;
    logic             event_s;
    logic [CNT_W-1:0] next_cnt_s;

    assign mode_s = mode_e'(bus.mode);

    // Next run length, detection event and next counter value.
    always_comb begin
        qual_s     = qualifies(mode_s, bus.w);
        next_run_s = run_r;
        event_s    = 1'b0;
        next_cnt_s = cnt_r;

        if (bus.en) begin
            // A mode change, empty run or bit change starts a fresh run.
            if ((mode_s != mode_q_r) || (run_r == {RW{1'b0}}) || (bus.w != bit_r)) begin
                if (qual_s) begin
                    next_run_s = RW'(1);
                end else begin
                    next_run_s = {RW{1'b0}};
                end
            end else if (run_r < RUN_MAX) begin
                next_run_s = run_r + RW'(1);
            end else begin
                // Run already complete: keep it (overlap) or restart counting.
                if (bus.overlap) begin
                    next_run_s = RUN_MAX;
                end else begin
                    next_run_s = RW'(1);
                end
            end
            event_s = (next_run_s == RUN_MAX);
        end else begin
            next_run_s = run_r;
            event_s    = 1'b0;
        end

        // Clear beats a coincident event; otherwise saturate at all-ones.
        if (bus.clr_cnt) begin
            next_cnt_s = {CNT_W{1'b0}};
        end else if (event_s && (cnt_r != CNT_MAX)) begin
            next_cnt_s = cnt_r + CNT_W'(1);
        end else begin
            next_cnt_s = cnt_r;
        end
    end

    // Run-tracking state: updated only on enabled samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_r    <= {RW{1'b0}};
            bit_r    <= 1'b0;
            mode_q_r <= MODE_ONES;
        end else if (bus.en) begin
            run_r    <= next_run_s;
            bit_r    <= bus.w;
            mode_q_r <= mode_s;
        end else begin
            run_r    <= run_r;
            bit_r    <= bit_r;
            mode_q_r <= mode_q_r;
        end
    end

    // Registered outputs: z mirrors run==RUN_LEN, pulse marks each event.
    always_ff @(posedge clk) begin
        if (reset) begin
            z_r     <= 1'b0;
            pulse_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            z_r     <= (next_run_s == RUN_MAX);
            pulse_r <= event_s;
            cnt_r   <= next_cnt_s;
        end
    end

    assign bus.z         = z_r;
    assign bus.det_pulse = pulse_r;
    assign bus.det_count = cnt_r;
endmodule

// File: tb/tb_secuencia_run_detector.sv
// Directed bench for secuencia_run_detector. Three instances cover the
// RUN_LEN/CNT_W combinations exercised; all share the stimulus signals.
module tb_secuencia_run_detector;
    logic       clk;
    logic       reset;
    logic       en;
    logic       w;
    logic [1:0] mode;
    logic       overlap;
    logic       clr_cnt;

    int n_cmp;
    int n_err;

    secuencia_run_detector_if #(.CNT_W(8)) if3 ();
    secuencia_run_detector_if #(.CNT_W(8)) if2 ();
    secuencia_run_detector_if #(.CNT_W(2)) if1 ();

    assign if3.en = en;  assign if3.w = w;  assign if3.mode = mode;
    assign if3.overlap = overlap;  assign if3.clr_cnt = clr_cnt;
    assign if2.en = en;  assign if2.w = w;  assign if2.mode = mode;
    assign if2.overlap = overlap;  assign if2.clr_cnt = clr_cnt;
    assign if1.en = en;  assign if1.w = w;  assign if1.mode = mode;
    assign if1.overlap = overlap;  assign if1.clr_cnt = clr_cnt;

    secuencia_run_detector #(.RUN_LEN(3), .CNT_W(8)) dut3 (.clk(clk), .reset(reset), .bus(if3));
    secuencia_run_detector #(.RUN_LEN(2), .CNT_W(8)) dut2 (.clk(clk), .reset(reset), .bus(if2));
    secuencia_run_detector #(.RUN_LEN(1), .CNT_W(2)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic wv);
        w = wv;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Expected per-sample values for the six-sample sequences.
    logic [5:0] wv_a;
    logic [5:0] z_a;
    int         c_a [6];

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b1; en = 1'b1; w = 1'b1; mode = 2'b00; overlap = 1'b1; clr_cnt = 1'b0;

        // Reset for two cycles with en=1, w=1.
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_z", if3.z, 0);
        check("rst_pulse", if3.det_pulse, 0);
        check("rst_cnt", if3.det_count, 0);
        reset = 1'b0;
        en = 1'b0;
        for (int i = 0; i < 5; i++) step(i[0]);
        check("hold_z", if3.z, 0);
        check("hold_pulse", if3.det_pulse, 0);
        check("hold_cnt", if3.det_count, 0);

        // Ones, overlap, RUN_LEN=3: w=1,1,1,1,1,0 with a hold after sample 3.
        do_reset();
        mode = 2'b00; overlap = 1'b1; en = 1'b1;
        wv_a = 6'b011111;  z_a = 6'b011100;
        c_a = '{0, 0, 1, 2, 3, 3};
        for (int i = 0; i < 6; i++) begin
            step(wv_a[i]);
            check($sformatf("ov_z%0d", i), if3.z, z_a[i]);
            check($sformatf("ov_p%0d", i), if3.det_pulse, z_a[i]);
            check($sformatf("ov_c%0d", i), if3.det_count, c_a[i]);
            if (i == 2) begin
                en = 1'b0;
                step(1'b0);
                step(1'b1);
                check("ovhold_z", if3.z, 1);
                check("ovhold_p", if3.det_pulse, 0);
                check("ovhold_c", if3.det_count, 1);
                en = 1'b1;
            end
        end

        // Ones, non-overlap, RUN_LEN=3: w=1 x6.
        do_reset();
        mode = 2'b00; overlap = 1'b0; en = 1'b1;
        z_a = 6'b100100;
        c_a = '{0, 0, 1, 1, 1, 2};
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            check($sformatf("nov_z%0d", i), if3.z, z_a[i]);
            check($sformatf("nov_p%0d", i), if3.det_pulse, z_a[i]);
            check($sformatf("nov_c%0d", i), if3.det_count, c_a[i]);
        end

        // Merged, non-overlap, RUN_LEN=2: w=0,0,1,1,0,1.
        do_reset();
        mode = 2'b10; overlap = 1'b0; en = 1'b1;
        wv_a = 6'b101100;  z_a = 6'b001010;
        c_a = '{0, 1, 1, 2, 2, 2};
        for (int i = 0; i < 6; i++) begin
            step(wv_a[i]);
            check($sformatf("mrg_z%0d", i), if2.z, z_a[i]);
            check($sformatf("mrg_p%0d", i), if2.det_pulse, z_a[i]);
            check($sformatf("mrg_c%0d", i), if2.det_count, c_a[i]);
        end

        // Mode change and disable, RUN_LEN=2.
        do_reset();
        mode = 2'b00; overlap = 1'b1; en = 1'b1;
        step(1'b1); check("mc_z0", if2.z, 0);
        step(1'b1); check("mc_z1", if2.z, 1);
        mode = 2'b01;
        step(1'b0); check("mc_z2", if2.z, 0);
        check("mc_p2", if2.det_pulse, 0);
        step(1'b0); check("mc_z3", if2.z, 1);
        check("mc_c3", if2.det_count, 2);
        mode = 2'b11;
        step(1'b0); check("off_z0", if2.z, 0);
        step(1'b0); check("off_z1", if2.z, 0);
        check("off_c", if2.det_count, 2);

        // Saturation and clear, RUN_LEN=1, CNT_W=2.
        do_reset();
        mode = 2'b00; overlap = 1'b1; en = 1'b1;
        c_a = '{1, 2, 3, 3, 3, 3};
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            check($sformatf("sat_c%0d", i), if1.det_count, c_a[i]);
            check($sformatf("sat_p%0d", i), if1.det_pulse, 1);
        end
        clr_cnt = 1'b1;
        step(1'b1);
        check("clr_c", if1.det_count, 0);
        check("clr_p", if1.det_pulse, 1);
        clr_cnt = 1'b0;
        overlap = 1'b0;
        step(1'b1); check("no1_c0", if1.det_count, 1); check("no1_p0", if1.det_pulse, 1);
        step(1'b1); check("no1_c1", if1.det_count, 2); check("no1_z1", if1.z, 1);
        step(1'b0); check("no1_z2", if1.z, 0); check("no1_p2", if1.det_pulse, 0);
        check("no1_c2", if1.det_count, 2);
        step(1'b1); check("no1_z3", if1.z, 1);
        reset = 1'b1;
        step(1'b1);
        check("mrst_z", if1.z, 0);
        check("mrst_p", if1.det_pulse, 0);
        check("mrst_c", if1.det_count, 0);
        check("mrst_z3", if3.z, 0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
